// File: rtl/de2_70_nios2_processor_jtag_debug_host.sv
// Virtual-JTAG scan host for the Nios II debug module.
// Each accepted command runs one scan: UIR, CDR, SDR (DR_WIDTH tck periods), UDR and RTI,
// one tck period per state apart from SDR. It then passes through DONE and returns to IDLE,
// pulsing rsp_valid with the captured data.
//
// Ports:
//   clk, reset_n        - clock, asynchronous active-low reset
//   cmd_valid/cmd_ready - request handshake; cmd_ir and cmd_data are latched on acceptance
//   rsp_valid           - one-clk pulse at scan end; rsp_data and rsp_ir hold until the next scan
//   vji_*               - registered drive into the debug module's virtual JTAG port
//   vji_tdo, vji_ir_out - returns from the debug module
module de2_70_nios2_processor_jtag_debug_host #(
  parameter int unsigned DR_WIDTH = 38,
  parameter int unsigned TCK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic [1:0]          rsp_ir,
  output logic                vji_tck,
  output logic                vji_tdi,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti,
  output logic [1:0]          vji_ir_in,
  input  logic                vji_tdo,
  input  logic [1:0]          vji_ir_out
);

  localparam int unsigned BitW = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
  localparam logic [7:0] DivMax = 8'(TCK_DIV - 1);
  localparam logic [BitW-1:0] BitMax = BitW'(DR_WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StUir, StCdr, StSdr, StUdr, StRti, StDone} state_e;

  state_e state_q, state_d;
  logic [7:0] div_q, div_d;
  logic phase_q, phase_d;  // 0: tck low half, 1: tck high half
  logic [BitW-1:0] bit_q, bit_d;
  logic [DR_WIDTH-1:0] shift_q, shift_d;
  logic [DR_WIDTH:0] shift_in;
  logic [1:0] ir_cap_q, ir_cap_d;
  logic [1:0] ir_in_q, ir_in_d;
  logic tck_q, tck_d, tdi_q, tdi_d;
  logic [4:0] strobe_q, strobe_d;  // {rti, udr, sdr, cdr, uir}
  logic rsp_valid_q, rsp_valid_d;
  logic [DR_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [1:0] rsp_ir_q, rsp_ir_d;
  logic cmd_ready_q, cmd_ready_d;

  logic accept, active, half_end, tck_rise, period_end;

  assign accept     = cmd_valid & cmd_ready_q;
  assign active     = (state_q != StIdle) && (state_q != StDone);
  assign half_end   = active && (div_q == DivMax);
  assign tck_rise   = half_end && !phase_q;
  assign period_end = half_end && phase_q;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      div_q       <= '0;
      phase_q     <= 1'b0;
      bit_q       <= '0;
      shift_q     <= '0;
      ir_cap_q    <= '0;
      ir_in_q     <= '0;
      tck_q       <= 1'b0;
      tdi_q       <= 1'b0;
      strobe_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_ir_q    <= '0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      phase_q     <= phase_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      ir_cap_q    <= ir_cap_d;
      ir_in_q     <= ir_in_d;
      tck_q       <= tck_d;
      tdi_q       <= tdi_d;
      strobe_q    <= strobe_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_ir_q    <= rsp_ir_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  // Next-state logic: scan state plus the tck divider and SDR bit counter
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    if (active) begin
      div_d = half_end ? 8'd0 : div_q + 8'd1;
      if (half_end) phase_d = ~phase_q;
    end
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StUir;
          div_d   = '0;
          phase_d = 1'b0;
        end
      end
      StUir: if (period_end) state_d = StCdr;
      StCdr: begin
        if (period_end) begin
          state_d = StSdr;
          bit_d   = '0;
        end
      end
      StSdr: begin
        if (period_end) begin
          if (bit_q == BitMax) state_d = StUdr;
          else bit_d = bit_q + 1'b1;
        end
      end
      StUdr:  if (period_end) state_d = StRti;
      StRti:  if (period_end) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic: next values of all registered outputs
  always_comb begin
    shift_in = {vji_tdo, shift_q};
    shift_d  = shift_q;
    if (accept) shift_d = cmd_data;
    else if (tck_rise && state_q == StSdr) shift_d = shift_in[DR_WIDTH:1];

    ir_in_d  = accept ? cmd_ir : ir_in_q;
    // Captured IR is staged internally so rsp_ir only moves when the scan completes
    ir_cap_d = (tck_rise && state_q == StCdr) ? vji_ir_out : ir_cap_q;

    tck_d = 1'b0;
    if (active) begin
      if (tck_rise) tck_d = 1'b1;
      else if (period_end) tck_d = 1'b0;
      else tck_d = tck_q;
    end

    // Strobes follow state_d, so they only move on a period boundary (start of low phase)
    strobe_d = {state_d == StRti, state_d == StUdr, state_d == StSdr,
                state_d == StCdr, state_d == StUir};

    tdi_d = 1'b0;
    if (state_d == StSdr) tdi_d = period_end ? shift_q[0] : tdi_q;

    rsp_valid_d = (state_q == StDone);
    rsp_data_d  = (state_q == StDone) ? shift_q : rsp_data_q;
    rsp_ir_d    = (state_q == StDone) ? ir_cap_q : rsp_ir_q;
    cmd_ready_d = (state_d == StIdle);
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_ir    = rsp_ir_q;
  assign vji_tck   = tck_q;
  assign vji_tdi   = tdi_q;
  assign vji_uir   = strobe_q[0];
  assign vji_cdr   = strobe_q[1];
  assign vji_sdr   = strobe_q[2];
  assign vji_udr   = strobe_q[3];
  assign vji_rti   = strobe_q[4];
  assign vji_ir_in = ir_in_q;

endmodule

// File: tb/tb_de2_70_nios2_processor_jtag_debug_host.sv
// Directed bench for the virtual-JTAG scan host: default-parameter instance plus a
// TCK_DIV=1 / DR_WIDTH=4 instance.
module tb_de2_70_nios2_processor_jtag_debug_host;

  localparam int unsigned DW = 38;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic cmd_valid, cmd_ready, rsp_valid;
  logic [1:0] cmd_ir, rsp_ir, vji_ir_in, vji_ir_out;
  logic [DW-1:0] cmd_data, rsp_data;
  logic vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti, vji_tdo;
  logic loop, tdo_force;
  assign vji_tdo = loop ? vji_tdi : tdo_force;

  de2_70_nios2_processor_jtag_debug_host dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ir(cmd_ir), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_ir(rsp_ir), .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_uir(vji_uir),
    .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr), .vji_rti(vji_rti),
    .vji_ir_in(vji_ir_in), .vji_tdo(vji_tdo), .vji_ir_out(vji_ir_out)
  );

  logic s_cmd_valid, s_cmd_ready, s_rsp_valid;
  logic [1:0] s_cmd_ir, s_rsp_ir, s_ir_in;
  logic [3:0] s_cmd_data, s_rsp_data;
  logic s_tck, s_tdi, s_uir, s_cdr, s_sdr, s_udr, s_rti;

  de2_70_nios2_processor_jtag_debug_host #(.DR_WIDTH(4), .TCK_DIV(1)) dut_s (
    .clk(clk), .reset_n(reset_n), .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready),
    .cmd_ir(s_cmd_ir), .cmd_data(s_cmd_data), .rsp_valid(s_rsp_valid), .rsp_data(s_rsp_data),
    .rsp_ir(s_rsp_ir), .vji_tck(s_tck), .vji_tdi(s_tdi), .vji_uir(s_uir),
    .vji_cdr(s_cdr), .vji_sdr(s_sdr), .vji_udr(s_udr), .vji_rti(s_rti),
    .vji_ir_in(s_ir_in), .vji_tdo(s_tdi), .vji_ir_out(2'b00)
  );

  // Monitors sample on the falling edge, away from the active edge
  int tck_rises = 0, sdr_cycles = 0, strobe_err = 0, rsp_pulses = 0;
  logic tck_prev = 1'b0, s_tck_prev = 1'b0;
  logic [4:0] mon_s, s_prev = '0;
  int mon_idx, last_idx = -1;
  logic [3:0] s_seq = '0;

  always @(negedge clk) begin
    mon_s = {vji_rti, vji_udr, vji_sdr, vji_cdr, vji_uir};
    if (vji_tck && !tck_prev) tck_rises++;
    if (vji_sdr) sdr_cycles++;
    if (rsp_valid) rsp_pulses++;
    if (mon_s != s_prev && vji_tck) strobe_err++;
    if (mon_s == 5'b0) last_idx = -1;
    else if ($countones(mon_s) != 1) strobe_err++;
    else begin
      mon_idx = $clog2(mon_s);
      if (mon_idx != last_idx) begin
        if (mon_idx != last_idx + 1) strobe_err++;
        last_idx = mon_idx;
      end
    end
    tck_prev = vji_tck;
    s_prev   = mon_s;
    if (s_sdr && s_tck && !s_tck_prev) s_seq = {s_seq[2:0], s_tdi};
    s_tck_prev = s_tck;
  end

  int total = 0, bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_scan(input logic [1:0] ir, input logic [DW-1:0] d);
    int n;
    n = 0;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    check("ready_before_scan", 64'(cmd_ready), 64'd1);
    cmd_ir = ir;
    cmd_data = d;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    cmd_ir = ~ir;  // later input changes must not disturb the running scan
    cmd_data = ~d;
  endtask

  task automatic wait_rsp(input bit pulse, output int lat);
    lat = 0;
    while (!rsp_valid && lat < 400) begin
      if (pulse) cmd_valid = (lat % 16 == 3) && (lat < 140);
      tick();
      lat++;
    end
    if (pulse) cmd_valid = 1'b0;
  endtask

  localparam logic [DW-1:0] DataA = 38'h2A_5555_AAAA;
  localparam logic [DW-1:0] DataB = 38'h0F_0F0F_0F0F;
  localparam logic [DW-1:0] Data1 = 38'h12_3456_789A;
  localparam logic [DW-1:0] Data2 = 38'h21_FEDC_BA98;
  localparam logic [DW-1:0] Data3 = 38'h15_A5A5_5A5A;

  initial begin
    int lat, r0, c0, p0;
    reset_n = 1'b0;
    cmd_valid = 1'b0; cmd_ir = '0; cmd_data = '0;
    loop = 1'b1; tdo_force = 1'b0; vji_ir_out = 2'b11;
    s_cmd_valid = 1'b0; s_cmd_ir = '0; s_cmd_data = '0;
    repeat (3) tick();

    // Reset state
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    check("rst_rsp_ir", 64'(rsp_ir), 64'd0);
    check("rst_vji", 64'({vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}), 64'd0);
    check("rst_ir_in", 64'(vji_ir_in), 64'd0);
    reset_n = 1'b1;
    check("ready_before_edge", 64'(cmd_ready), 64'd0);
    tick();
    check("ready_after_release", 64'(cmd_ready), 64'd1);
    check("s_ready_after_release", 64'(s_cmd_ready), 64'd1);

    // Scan A: loopback, data returns unchanged
    r0 = tck_rises; c0 = sdr_cycles;
    start_scan(2'b01, DataA);
    check("a_ir_in", 64'(vji_ir_in), 64'h1);
    check("a_busy", 64'(cmd_ready), 64'd0);
    wait_rsp(1'b0, lat);
    check("a_latency", 64'(lat), 64'd169);
    check("a_rsp_data", 64'(rsp_data), 64'(DataA));
    check("a_rsp_ir", 64'(rsp_ir), 64'h3);
    check("a_tck_rises", 64'(tck_rises - r0), 64'd42);
    check("a_sdr_cycles", 64'(sdr_cycles - c0), 64'd152);
    check("a_ready_at_rsp", 64'(cmd_ready), 64'd1);
    tick();
    check("a_pulse_width", 64'(rsp_valid), 64'd0);
    check("a_ir_in_hold", 64'(vji_ir_in), 64'h1);

    // Scan B: tdo tied high, response fields stay put until the scan completes
    loop = 1'b0; tdo_force = 1'b1; vji_ir_out = 2'b10;
    c0 = sdr_cycles;
    start_scan(2'b10, DataB);
    repeat (20) tick();
    check("b_rsp_ir_stable", 64'(rsp_ir), 64'h3);
    check("b_rsp_data_stable", 64'(rsp_data), 64'(DataA));
    wait_rsp(1'b0, lat);
    check("b_latency", 64'(lat + 20), 64'd169);
    check("b_rsp_data", 64'(rsp_data), 64'h3F_FFFF_FFFF);
    check("b_rsp_ir", 64'(rsp_ir), 64'h2);
    check("b_sdr_cycles", 64'(sdr_cycles - c0), 64'd152);
    check("b_ir_in", 64'(vji_ir_in), 64'h2);

    // Back-to-back with cmd_valid held high, then ignored pulses during scan 2
    loop = 1'b1; vji_ir_out = 2'b01;
    tick();
    cmd_ir = 2'b01; cmd_data = Data1; cmd_valid = 1'b1;
    tick();
    check("bb_ir_in_1", 64'(vji_ir_in), 64'h1);
    cmd_ir = 2'b11; cmd_data = Data2;
    wait_rsp(1'b0, lat);
    check("bb_latency_1", 64'(lat), 64'd169);
    check("bb_rsp_data_1", 64'(rsp_data), 64'(Data1));
    check("bb_ready_at_rsp", 64'(cmd_ready), 64'd1);
    tick();
    check("bb_accept_2", 64'({cmd_ready, vji_uir}), 64'b01);
    check("bb_ir_in_2", 64'(vji_ir_in), 64'h3);
    cmd_valid = 1'b0;
    wait_rsp(1'b1, lat);
    check("bb_latency_2", 64'(lat), 64'd169);
    check("bb_rsp_data_2", 64'(rsp_data), 64'(Data2));
    check("bb_rsp_ir_2", 64'(rsp_ir), 64'h1);
    repeat (5) tick();
    check("bb_no_queued", 64'({cmd_ready, vji_uir}), 64'b10);

    // Reset in the middle of SDR
    p0 = rsp_pulses;
    start_scan(2'b01, Data3);
    repeat (80) tick();
    check("mid_in_sdr", 64'(vji_sdr), 64'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_vji", 64'({vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}),
          64'd0);
    check("mid_rst_rsp", 64'({rsp_valid, cmd_ready, rsp_ir, vji_ir_in}), 64'd0);
    check("mid_rst_rsp_data", 64'(rsp_data), 64'd0);
    r0 = tck_rises;
    repeat (4) tick();
    check("mid_rst_no_tck", 64'(tck_rises - r0), 64'd0);
    check("mid_rst_no_rsp", 64'(rsp_pulses - p0), 64'd0);
    reset_n = 1'b1;
    tick();
    check("mid_ready_after", 64'(cmd_ready), 64'd1);
    start_scan(2'b10, Data3);
    wait_rsp(1'b0, lat);
    check("mid_latency", 64'(lat), 64'd169);
    check("mid_rsp_data", 64'(rsp_data), 64'(Data3));
    tick();

    // Small instance: TCK_DIV=1, DR_WIDTH=4
    s_cmd_ir = 2'b01; s_cmd_data = 4'b1001; s_cmd_valid = 1'b1;
    tick();
    s_cmd_valid = 1'b0; s_cmd_data = 4'b0110;
    lat = 0;
    while (!s_rsp_valid && lat < 100) begin
      tick();
      lat++;
    end
    check("s_latency", 64'(lat), 64'd17);
    check("s_rsp_data", 64'(s_rsp_data), 64'b1001);
    check("s_tdi_seq", 64'(s_seq), 64'b1001);
    tick();

    check("strobe_order", 64'(strobe_err), 64'd0);
    check("rsp_pulse_count", 64'(rsp_pulses), 64'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
